// File: rtl/pl_hazard_ctrl.sv
// rtl/pl_hazard_ctrl.sv - pipeline stall/flush controller with data-memory wait FSM.
// Define PL_HAZARD_FWD_EN when the datapath forwards, so only load-use hazards stall.
module pl_hazard_ctrl #(
  parameter logic [7:0] MEM_TIMEOUT = 8'd255
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [4:0]  drs,
  input  logic [4:0]  drt,
  input  logic        duse_rs,
  input  logic        duse_rt,
  input  logic        ewreg,
  input  logic        em2reg,
  input  logic [4:0]  ern,
  input  logic        mwreg,
  input  logic [4:0]  mrn,
  input  logic        wwreg,
  input  logic [4:0]  wrn,
  input  logic        ebranch,
  input  logic        mreq,
  input  logic        dmem_ready,
  output logic        pc_en,
  output logic        ifid_en,
  output logic        ifid_flush,
  output logic        idex_en,
  output logic        idex_bubble,
  output logic        exmem_en,
  output logic        memwb_en,
  output logic        memwb_bubble,
  output logic        mem_err,
  output logic [15:0] stall_cnt
);

  typedef enum logic {RUN = 1'b0, MWAIT = 1'b1} state_t;

  state_t      state_q, state_d;
  logic [7:0]  wait_q, wait_d;
  logic        mem_err_q;
  logic [15:0] stall_cnt_q;

  logic hit_e, load_use, data_haz, timeout, mem_hold;

  assign hit_e    = ewreg & (ern != 5'd0) &
                    ((duse_rs & (drs == ern)) | (duse_rt & (drt == ern)));
  assign load_use = em2reg & hit_e;

`ifdef PL_HAZARD_FWD_EN
  assign data_haz = load_use;
`else
  // Without forwarding every in-flight writer of a source register blocks ID.
  logic hit_m, hit_w;
  assign hit_m    = mwreg & (mrn != 5'd0) &
                    ((duse_rs & (drs == mrn)) | (duse_rt & (drt == mrn)));
  assign hit_w    = wwreg & (wrn != 5'd0) &
                    ((duse_rs & (drs == wrn)) | (duse_rt & (drt == wrn)));
  assign data_haz = load_use | hit_e | hit_m | hit_w;
`endif

  assign timeout  = (state_q == MWAIT) & ~dmem_ready & (wait_q == MEM_TIMEOUT);
  assign mem_hold = ~dmem_ready &
                    (((state_q == RUN) & mreq) | ((state_q == MWAIT) & (wait_q != MEM_TIMEOUT)));

  always_comb begin
    pc_en        = 1'b1;
    ifid_en      = 1'b1;
    ifid_flush   = 1'b0;
    idex_en      = 1'b1;
    idex_bubble  = 1'b0;
    exmem_en     = 1'b1;
    memwb_en     = 1'b1;
    memwb_bubble = 1'b0;
    state_d      = RUN;
    wait_d       = wait_q;
    if (reset) begin
      wait_d = 8'd0;
    end else if (mem_hold) begin
      pc_en        = 1'b0;
      ifid_en      = 1'b0;
      idex_en      = 1'b0;
      exmem_en     = 1'b0;
      memwb_bubble = 1'b1;
      state_d      = MWAIT;
      wait_d       = (state_q == RUN) ? 8'd0 : wait_q + 8'd1;
    end else if (ebranch) begin
      ifid_flush  = 1'b1;
      idex_bubble = 1'b1;
    end else if (data_haz) begin
      pc_en       = 1'b0;
      ifid_en     = 1'b0;
      idex_bubble = 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= RUN;
      wait_q      <= 8'd0;
      mem_err_q   <= 1'b0;
      stall_cnt_q <= 16'd0;
    end else begin
      state_q   <= state_d;
      wait_q    <= wait_d;
      mem_err_q <= timeout;
      if (!pc_en && stall_cnt_q != 16'hFFFF)
        stall_cnt_q <= stall_cnt_q + 16'd1;
    end
  end

  assign mem_err   = mem_err_q;
  assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_pl_hazard_ctrl.sv
// tb/tb_pl_hazard_ctrl.sv - pipeline-model bench for pl_hazard_ctrl.
module tb_pl_hazard_ctrl;
  localparam logic [7:0] TMO = 8'd3;

  logic clock = 1'b0;
  logic reset, duse_rs, duse_rt, ewreg, em2reg, mwreg, wwreg, ebranch, mreq, dmem_ready;
  logic [4:0] drs, drt, ern, mrn, wrn;
  logic pc_en, ifid_en, ifid_flush, idex_en, idex_bubble, exmem_en, memwb_en, memwb_bubble, mem_err;
  logic [15:0] stall_cnt;

  pl_hazard_ctrl #(.MEM_TIMEOUT(TMO)) dut (
    .clock(clock), .reset(reset), .drs(drs), .drt(drt), .duse_rs(duse_rs), .duse_rt(duse_rt),
    .ewreg(ewreg), .em2reg(em2reg), .ern(ern), .mwreg(mwreg), .mrn(mrn), .wwreg(wwreg), .wrn(wrn),
    .ebranch(ebranch), .mreq(mreq), .dmem_ready(dmem_ready), .pc_en(pc_en), .ifid_en(ifid_en),
    .ifid_flush(ifid_flush), .idex_en(idex_en), .idex_bubble(idex_bubble), .exmem_en(exmem_en),
    .memwb_en(memwb_en), .memwb_bubble(memwb_bubble), .mem_err(mem_err), .stall_cnt(stall_cnt)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic [4:0] rs; logic [4:0] rt; logic urs; logic urt;
    logic wreg; logic m2reg; logic [4:0] rn; logic br; logic mreq;
  } ins_t;

  // Bench-side pipeline: instructions move according to the expected enables.
  ins_t id_s, ex_s, mem_s, wb_s;
  bit   random_mode;

  bit in_wait, err_m;
  int waited, stall_m;
  bit e_pc, e_ifid, e_flush, e_idex, e_bub, e_exmem, e_memwb, e_mwbub, timeout_m, hold_m;

  int n_vec = 0, n_err = 0;
  int cyc, c_stall, c_mwbub, c_err, c_flush, first_stall, last_stall, flush_at;
  logic s_pc, s_flush, s_bub, s_ifid, s_idex, s_exmem, s_memwb, s_mwbub;
  logic [15:0] s_cnt;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s cyc=%0d actual=%0h required=%0h", name, cyc, act, exp);
    end
  endtask

  function automatic ins_t rand_ins();
    ins_t i;
    i.rs    = 5'($urandom_range(0, 7));
    i.rt    = 5'($urandom_range(0, 7));
    i.urs   = 1'($urandom_range(0, 1));
    i.urt   = 1'($urandom_range(0, 1));
    i.wreg  = 1'($urandom_range(0, 1));
    i.rn    = 5'($urandom_range(0, 7));
    i.m2reg = i.wreg && ($urandom_range(0, 2) == 0);
    i.mreq  = i.m2reg || ($urandom_range(0, 7) == 0);
    i.br    = ($urandom_range(0, 9) == 0);
    return i;
  endfunction

  function automatic bit reads(input ins_t i, input logic [4:0] r);
    return (r != 5'd0) && ((i.urs && i.rs == r) || (i.urt && i.rt == r));
  endfunction

  task automatic model_eval();
    bit haz;
`ifdef PL_HAZARD_FWD_EN
    haz = ex_s.wreg && ex_s.m2reg && reads(id_s, ex_s.rn);
`else
    haz = (ex_s.wreg && reads(id_s, ex_s.rn)) || (mem_s.wreg && reads(id_s, mem_s.rn)) ||
          (wb_s.wreg && reads(id_s, wb_s.rn));
`endif
    {e_pc, e_ifid, e_idex, e_exmem, e_memwb} = 5'b11111;
    {e_flush, e_bub, e_mwbub} = 3'b000;
    timeout_m = !reset && in_wait && !dmem_ready && waited == int'(TMO);
    hold_m    = !reset && !dmem_ready && ((!in_wait && mreq) || (in_wait && waited < int'(TMO)));
    if (hold_m) begin
      {e_pc, e_ifid, e_idex, e_exmem} = 4'b0000;
      e_mwbub = 1'b1;
    end else if (!reset && ex_s.br) begin
      e_flush = 1'b1; e_bub = 1'b1;
    end else if (!reset && haz) begin
      e_pc = 1'b0; e_ifid = 1'b0; e_bub = 1'b1;
    end
  endtask

  task automatic compare();
    chk("pc_en", 16'(pc_en), 16'(e_pc));
    chk("ifid_en", 16'(ifid_en), 16'(e_ifid));
    chk("ifid_flush", 16'(ifid_flush), 16'(e_flush));
    chk("idex_en", 16'(idex_en), 16'(e_idex));
    chk("idex_bubble", 16'(idex_bubble), 16'(e_bub));
    chk("exmem_en", 16'(exmem_en), 16'(e_exmem));
    chk("memwb_en", 16'(memwb_en), 16'(e_memwb));
    chk("memwb_bubble", 16'(memwb_bubble), 16'(e_mwbub));
    chk("mem_err", 16'(mem_err), 16'(err_m));
    chk("stall_cnt", stall_cnt, 16'(stall_m));
  endtask

  task automatic step(input bit rst, input bit rdy);
    reset = rst; dmem_ready = rdy;
    drs = id_s.rs; drt = id_s.rt; duse_rs = id_s.urs; duse_rt = id_s.urt;
    ewreg = ex_s.wreg; em2reg = ex_s.m2reg; ern = ex_s.rn; ebranch = ex_s.br;
    mwreg = mem_s.wreg; mrn = mem_s.rn; mreq = mem_s.mreq;
    wwreg = wb_s.wreg; wrn = wb_s.rn;
    @(negedge clock);
    model_eval();
    compare();
    {s_pc, s_flush, s_bub, s_ifid, s_idex, s_exmem, s_memwb, s_mwbub} =
      {pc_en, ifid_flush, idex_bubble, ifid_en, idex_en, exmem_en, memwb_en, memwb_bubble};
    s_cnt = stall_cnt;
    if (!pc_en) begin
      c_stall++;
      if (first_stall < 0) first_stall = cyc;
      last_stall = cyc;
    end
    if (memwb_bubble) c_mwbub++;
    if (mem_err) c_err++;
    if (ifid_flush) begin c_flush++; flush_at = cyc; end
    cyc++;
    @(posedge clock);
    if (rst) begin
      in_wait = 0; waited = 0; err_m = 0; stall_m = 0;
    end else begin
      err_m = timeout_m;
      if (!e_pc && stall_m < 65535) stall_m++;
      if (hold_m) begin
        if (!in_wait) begin in_wait = 1; waited = 0; end
        else waited++;
      end else in_wait = 0;
    end
    if (e_memwb) wb_s = e_mwbub ? '0 : mem_s;
    if (e_exmem) mem_s = ex_s;
    if (e_idex) ex_s = e_bub ? '0 : id_s;
    if (e_ifid) id_s = e_flush ? '0 : (random_mode ? rand_ins() : '0);
    #1;
  endtask

  task automatic restart();
    step(1'b1, 1'b1);
    id_s = '0; ex_s = '0; mem_s = '0; wb_s = '0;
    cyc = 0; c_stall = 0; c_mwbub = 0; c_err = 0; c_flush = 0;
    first_stall = -1; last_stall = -1; flush_at = -1;
  endtask

  task automatic load_in_mem();
    mem_s.wreg = 1; mem_s.m2reg = 1; mem_s.rn = 5'd7; mem_s.mreq = 1;
  endtask

  int exp_stalls;

  initial begin
    random_mode = 0;
    id_s = '0; ex_s = '0; mem_s = '0; wb_s = '0;
    in_wait = 0; waited = 0; err_m = 0; stall_m = 0; cyc = 0;
    restart();
    restart();
    chk("reset_stall_cnt", stall_cnt, 16'd0);
    chk("reset_pc_en", 16'(s_pc), 16'd1);

    // Writer of r5 in EX, reader of r5 in ID.
    restart();
    ex_s.wreg = 1; ex_s.rn = 5'd5;
`ifdef PL_HAZARD_FWD_EN
    ex_s.m2reg = 1; ex_s.mreq = 1; exp_stalls = 1;
`else
    exp_stalls = 3;
`endif
    id_s.rs = 5'd5; id_s.urs = 1;
    repeat (6) step(1'b0, 1'b1);
    chk("raw_stall_cycles", 16'(c_stall), 16'(exp_stalls));
    chk("raw_stall_cnt", stall_cnt, 16'(exp_stalls));
    chk("raw_consecutive", 16'(last_stall - first_stall + 1), 16'(exp_stalls));

    // r0 destination never stalls.
    restart();
    ex_s.wreg = 1; ex_s.m2reg = 1; ex_s.rn = 5'd0; id_s.rs = 5'd0; id_s.urs = 1;
    repeat (4) step(1'b0, 1'b1);
    chk("r0_no_stall", 16'(c_stall), 16'd0);

    // Four not-ready cycles, ready on the fifth.
    restart();
    load_in_mem();
    repeat (4) step(1'b0, 1'b0);
    step(1'b0, 1'b1);
    chk("mwait_release_pc", 16'(s_pc), 16'd1);
    repeat (2) step(1'b0, 1'b1);
    chk("mwait_stalls", 16'(c_stall), 16'd4);
    chk("mwait_bubbles", 16'(c_mwbub), 16'd4);
    chk("mwait_last_stall", 16'(last_stall), 16'd3);
    chk("mwait_no_err", 16'(c_err), 16'd0);

    // Zero-wait access.
    restart();
    load_in_mem();
    step(1'b0, 1'b1);
    chk("zero_wait_pc", 16'(s_pc), 16'd1);

    // Timeout with ready held low.
    restart();
    load_in_mem();
    repeat (8) step(1'b0, 1'b0);
    chk("tmo_err_pulses", 16'(c_err), 16'd1);
    chk("tmo_stalls", 16'(c_stall), 16'd4);
    chk("tmo_last_stall", 16'(last_stall), 16'd3);

    // Branch beats load-use.
    restart();
    ex_s.br = 1; ex_s.wreg = 1; ex_s.m2reg = 1; ex_s.rn = 5'd5; id_s.rs = 5'd5; id_s.urs = 1;
    step(1'b0, 1'b1);
    chk("br_flush", 16'(s_flush), 16'd1);
    chk("br_bubble", 16'(s_bub), 16'd1);
    chk("br_pc", 16'(s_pc), 16'd1);

    // Branch during MWAIT flushes only on release.
    restart();
    load_in_mem(); ex_s.br = 1;
    repeat (2) step(1'b0, 1'b0);
    repeat (2) step(1'b0, 1'b1);
    chk("br_wait_flushes", 16'(c_flush), 16'd1);
    chk("br_wait_flush_at", 16'(flush_at), 16'd2);

    // Reset in the middle of MWAIT.
    restart();
    load_in_mem();
    repeat (2) step(1'b0, 1'b0);
    step(1'b1, 1'b0);
    chk("rst_mid_enables", 16'({s_pc, s_ifid, s_idex, s_exmem, s_memwb}), 16'h1F);
    chk("rst_mid_bubbles", 16'({s_flush, s_bub, s_mwbub}), 16'h0);
    step(1'b0, 1'b0);
    chk("post_rst_cnt", s_cnt, 16'd0);
    chk("post_rst_pc", 16'(s_pc), 16'd1);

    // Random pipeline traffic with alternating memory latency regimes.
    random_mode = 1;
    restart();
    id_s = rand_ins(); ex_s = rand_ins(); mem_s = rand_ins(); wb_s = rand_ins();
    for (int i = 0; i < 4000; i++) begin
      bit rdy;
      rdy = ((i / 500) % 2 == 1) ? ($urandom_range(0, 9) != 0) : ($urandom_range(0, 9) < 3);
      step($urandom_range(0, 199) == 0, rdy);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/pl_hazard_ctrl.md
PL_HAZARD_CTRL -- requirements
Module: pl_hazard_ctrl

Interface
REQ-001 SHALL have parameter MEM_TIMEOUT, default 8'd255, the maximum number of MWAIT cycles before abort.
REQ-002 SHALL have ports, one per line:
  clock  input  1  pipeline clock, all state on rising edge
  reset  input  1  synchronous, active-high
  drs  input  5  ID-stage source register rs
  drt  input  5  ID-stage source register rt
  duse_rs  input  1  ID instruction reads rs
  duse_rt  input  1  ID instruction reads rt
  ewreg  input  1  EX instruction writes a register
  em2reg  input  1  EX instruction is a load
  ern  input  5  EX destination register
  mwreg  input  1  MEM instruction writes a register
  mrn  input  5  MEM destination register
  wwreg  input  1  WB instruction writes a register
  wrn  input  5  WB destination register
  ebranch  input  1  EX branch/jump resolved taken
  mreq  input  1  MEM instruction accesses data memory
  dmem_ready  input  1  data memory completes the access this cycle
  pc_en  output  1  PC load enable
  ifid_en  output  1  IF/ID register load enable
  ifid_flush  output  1  IF/ID loads a NOP
  idex_en  output  1  ID/EX register load enable
  idex_bubble  output  1  ID/EX loads a NOP (wreg=0, m2reg=0)
  exmem_en  output  1  EX/MEM register load enable
  memwb_en  output  1  MEM/WB register load enable
  memwb_bubble  output  1  MEM/WB loads wwreg=0, wm2reg=0
  mem_err  output  1  one-cycle pulse on memory timeout
  stall_cnt  output  16  saturating count of cycles with pc_en=0

Function
REQ-003 SHALL implement a two-state FSM, RUN and MWAIT; all outputs except mem_err and stall_cnt are combinational from state and inputs.
REQ-004 RUN, mreq=1, dmem_ready=0: SHALL go to MWAIT; in this cycle pc_en, ifid_en, idex_en and exmem_en SHALL be 0, memwb_en=1 and memwb_bubble=1.
REQ-005 MWAIT, dmem_ready=0: SHALL hold the same outputs as REQ-004 and increment the 8-bit wait counter.
REQ-006 MWAIT, dmem_ready=1: SHALL return to RUN; in this cycle all enables are 1 and memwb_bubble=0, and the branch and load-use rules of REQ-007 and REQ-008 apply.
REQ-007 RUN or MWAIT release, ebranch=1: SHALL drive pc_en=1, ifid_flush=1 and idex_bubble=1; branch overrides load-use.
REQ-008 Load-use without a branch: the hazard is em2reg & ewreg & ern!=0 & ((duse_rs & drs==ern) | (duse_rt & drt==ern)). It SHALL drive pc_en=0, ifid_en=0 and idex_bubble=1, and insert exactly one bubble per load.
REQ-009 Memory stall SHALL have highest priority; ebranch and load-use SHALL be ignored while the memory stall is active and re-evaluated on the release cycle.
REQ-010 Wait counter SHALL clear on entry to MWAIT. When it equals MEM_TIMEOUT with dmem_ready=0, the block SHALL go to RUN, pulse mem_err for 1 cycle and release the pipeline as in REQ-006.
REQ-011 Register $0 SHALL never cause a hazard.
REQ-012 stall_cnt SHALL increment on every cycle with pc_en=0 and saturate at 16'hFFFF.
REQ-013 mreq=1 with dmem_ready=1 in RUN SHALL cause no stall; the access has zero wait.

Reset
REQ-014 reset=1 at a clock edge SHALL force state RUN, wait counter 0, mem_err=0 and stall_cnt=0, including when it occurs mid-MWAIT.
REQ-015 While reset=1, outputs SHALL be pc_en=ifid_en=idex_en=exmem_en=memwb_en=1 and ifid_flush=idex_bubble=memwb_bubble=0.

Configuration
REQ-016 Macro PL_HAZARD_FWD_EN defined: forwarding exists and only the REQ-008 load-use hazard stalls.
REQ-017 PL_HAZARD_FWD_EN undefined: any RAW match against EX (ewreg), MEM (mwreg) or WB (wwreg) with a nonzero destination SHALL stall as in REQ-008. The stall SHALL repeat each cycle until no match remains, giving up to 3 bubbles.

Verification
REQ-018 Load r5, then add using rs=r5 (FWD_EN defined) -> exactly one cycle with pc_en=0 and idex_bubble=1, stall_cnt=1.
REQ-019 Same sequence with FWD_EN undefined and a non-load writer of r5 -> 3 consecutive stall cycles, stall_cnt=3.
REQ-020 mreq=1 with dmem_ready low for 4 cycles -> 4 stall cycles with memwb_bubble=1, release on cycle 5, mem_err=0.
REQ-021 MEM_TIMEOUT=3 with dmem_ready held 0 -> mem_err pulse exactly once, FSM in RUN, pipeline released.
REQ-022 ebranch=1 together with a load-use match -> ifid_flush=1, idex_bubble=1, pc_en=1; ebranch=1 during MWAIT -> flush occurs on the release cycle only.
REQ-023 reset=1 asserted during MWAIT -> next cycle state RUN, stall_cnt=0 and all enables 1.
